// File: rtl/fir_pkg.sv
// Shared FIR sample definitions.
// Used by the FIR core and its downstream output stages.
package fir_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/fir_out_decim_fifo_sample_fifo.sv
// First-word-fall-through sample FIFO with push/pop arbitration.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module sample_fifo
    import fir_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  sample_t                  wr_data,
    input  logic                     pop_req,
    output sample_t                  rd_data,
    output logic                     empty,
    output logic                     full,
    output logic                     accepted,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    sample_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            pop;

    assign empty    = (level == '0);
    assign full     = (level == (AW+1)'(DEPTH));
    assign pop      = pop_req & ~empty;
    assign accepted = push & (~full | pop);
    assign rd_data  = mem[rd_ptr];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (accepted) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (accepted) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({accepted, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fir_out_decim_fifo.sv
// FIR output decimator feeding a ready/valid FWFT FIFO; drops on full.
// Define FIR_OUT_DECIM_FIFO_DROP_CNT_EN to add the drop_count output.
module fir_out_decim_fifo
    import fir_pkg::*;
#(
    parameter int DECIM = 4,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  sample_t                in_sample,
    input  logic                   out_ready,
    output logic                   out_valid,
    output sample_t                out_sample,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    input  logic                   clr_ovf
`ifdef FIR_OUT_DECIM_FIFO_DROP_CNT_EN
    ,
    output logic [15:0]            drop_count
`endif
);

    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [PW-1:0] phase;
    logic          keep;
    logic          accepted;
    logic          drop;
    logic          empty;
    logic          full;
    sample_t       rd_data;

    assign keep = in_valid & (phase == '0);
    assign drop = keep & ~accepted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
        end else if (in_valid) begin
            if (phase == PW'(DECIM - 1)) begin
                phase <= '0;
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

    sample_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (keep),
        .wr_data  (in_sample),
        .pop_req  (out_ready),
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
        .accepted (accepted),
        .level    (level)
    );

    assign out_valid  = ~empty;
    assign out_sample = empty ? '0 : rd_data;

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

`ifdef FIR_OUT_DECIM_FIFO_DROP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
        end else if (drop) begin
            if (clr_ovf) begin
                drop_count <= 16'd1;
            end else if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end else if (clr_ovf) begin
            drop_count <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_fir_out_decim_fifo.sv
// Directed bench for fir_out_decim_fifo.
// Three instances cover DECIM = 4, 1 and 2 with DEPTH = 16.
module tb_fir_out_decim_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic        v4 = 0, r4 = 0, c4 = 0, ov4, ovf4;
    logic [15:0] s4 = 0, o4;
    logic [4:0]  l4;

    logic        v1 = 0, r1 = 0, c1 = 0, ov1, ovf1;
    logic [15:0] s1 = 0, o1;
    logic [4:0]  l1;

    logic        v2 = 0, r2 = 0, c2 = 0, ov2, ovf2;
    logic [15:0] s2 = 0, o2;
    logic [4:0]  l2;

`ifdef FIR_OUT_DECIM_FIFO_DROP_CNT_EN
    logic [15:0] dc4, dc1, dc2;
`endif

    fir_out_decim_fifo #(.DECIM(4), .DEPTH(16)) u4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_sample(s4),
        .out_ready(r4), .out_valid(ov4), .out_sample(o4),
        .level(l4), .overflow(ovf4), .clr_ovf(c4)
`ifdef FIR_OUT_DECIM_FIFO_DROP_CNT_EN
        , .drop_count(dc4)
`endif
    );

    fir_out_decim_fifo #(.DECIM(1), .DEPTH(16)) u1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_sample(s1),
        .out_ready(r1), .out_valid(ov1), .out_sample(o1),
        .level(l1), .overflow(ovf1), .clr_ovf(c1)
`ifdef FIR_OUT_DECIM_FIFO_DROP_CNT_EN
        , .drop_count(dc1)
`endif
    );

    fir_out_decim_fifo #(.DECIM(2), .DEPTH(16)) u2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_sample(s2),
        .out_ready(r2), .out_valid(ov2), .out_sample(o2),
        .level(l2), .overflow(ovf2), .clr_ovf(c2)
`ifdef FIR_OUT_DECIM_FIFO_DROP_CNT_EN
        , .drop_count(dc2)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] q4 [$];
    int          max_l4;

    initial begin
        // reset state
        step();
        check("rst_valid", 32'(ov1), 32'd0);
        check("rst_sample", 32'(o1), 32'd0);
        check("rst_level", 32'(l1), 32'd0);
        check("rst_ovf", 32'(ovf1), 32'd0);
        rst = 1'b0;
        step();

        // DECIM=4 decimation, consumer always ready
        max_l4 = 0;
        r4 = 1;
        for (int i = 1; i <= 12; i++) begin
            v4 = 1;
            s4 = 16'(i);
            step();
            if (ov4) q4.push_back(o4);
            if (int'(l4) > max_l4) max_l4 = int'(l4);
        end
        v4 = 0;
        step();
        check("d4_count", 32'(q4.size()), 32'd3);
        if (q4.size() == 3) begin
            check("d4_out0", 32'(q4[0]), 32'd1);
            check("d4_out1", 32'(q4[1]), 32'd5);
            check("d4_out2", 32'(q4[2]), 32'd9);
        end
        check("d4_maxlvl", 32'(max_l4), 32'd1);
        check("d4_ovf", 32'(ovf4), 32'd0);

        // DECIM=1 overflow: 20 samples into 16 slots
        r1 = 0;
        for (int i = 0; i < 20; i++) begin
            v1 = 1;
            s1 = 16'(100 + i);
            step();
        end
        v1 = 0;
        check("ovf_level", 32'(l1), 32'd16);
        check("ovf_flag", 32'(ovf1), 32'd1);
`ifdef FIR_OUT_DECIM_FIFO_DROP_CNT_EN
        check("ovf_dcnt", 32'(dc1), 32'd4);
`endif
        r1 = 1;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("drain%0d", k), 32'(o1), 32'(100 + k));
            step();
        end
        r1 = 0;
        check("drain_valid", 32'(ov1), 32'd0);
        check("drain_zero", 32'(o1), 32'd0);
        check("drain_level", 32'(l1), 32'd0);

        // clear, then full FIFO with simultaneous push and pop
        c1 = 1;
        step();
        c1 = 0;
        check("clr_ovf", 32'(ovf1), 32'd0);
`ifdef FIR_OUT_DECIM_FIFO_DROP_CNT_EN
        check("clr_dcnt", 32'(dc1), 32'd0);
`endif
        for (int i = 0; i < 16; i++) begin
            v1 = 1;
            s1 = 16'(200 + i);
            step();
        end
        check("full_level", 32'(l1), 32'd16);
        s1 = 16'd216;
        r1 = 1;
        step();
        v1 = 0;
        r1 = 0;
        check("pp_level", 32'(l1), 32'd16);
        check("pp_ovf", 32'(ovf1), 32'd0);
        check("pp_head", 32'(o1), 32'd201);
        r1 = 1;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("pp_drain%0d", k), 32'(o1), 32'(201 + k));
            step();
        end
        r1 = 0;
        check("pp_empty", 32'(l1), 32'd0);

        // signed extremes pass through bit-exact
        v1 = 1;
        s1 = 16'h8000;
        step();
        check("sgn_min", 32'(o1), 32'h8000);
        s1 = 16'h7FFF;
        step();
        v1 = 0;
        check("sgn_level", 32'(l1), 32'd2);
        r1 = 1;
        check("sgn_head", 32'(o1), 32'h8000);
        step();
        check("sgn_max", 32'(o1), 32'h7FFF);
        step();
        r1 = 0;
        check("sgn_gate_v", 32'(ov1), 32'd0);
        check("sgn_gate_s", 32'(o1), 32'd0);

        // DECIM=2 with in_valid toggling: phase frozen when idle
        r2 = 0;
        for (int i = 0; i < 8; i++) begin
            v2 = (i % 2 == 0);
            s2 = 16'(10 + i);
            step();
        end
        v2 = 0;
        check("tog_level", 32'(l2), 32'd2);
        r2 = 1;
        check("tog_first", 32'(o2), 32'd10);
        step();
        check("tog_second", 32'(o2), 32'd14);
        step();
        r2 = 0;
        check("tog_empty", 32'(ov2), 32'd0);

        // mid-stream async reset with level=5 and overflow set
        for (int i = 0; i < 21; i++) begin
            v1 = 1;
            s1 = 16'(300 + i);
            step();
        end
        v1 = 0;
        r1 = 1;
        for (int i = 0; i < 11; i++) step();
        r1 = 0;
        v2 = 1;
        s2 = 16'd50;
        step();
        v2 = 0;
        check("pre_level", 32'(l1), 32'd5);
        check("pre_ovf", 32'(ovf1), 32'd1);
        #3;
        rst = 1;
        #1;
        check("arst_valid", 32'(ov1), 32'd0);
        check("arst_sample", 32'(o1), 32'd0);
        check("arst_level", 32'(l1), 32'd0);
        check("arst_ovf", 32'(ovf1), 32'd0);
        check("arst_lvl2", 32'(l2), 32'd0);
`ifdef FIR_OUT_DECIM_FIFO_DROP_CNT_EN
        check("arst_dcnt", 32'(dc1), 32'd0);
`endif
        #1;
        rst = 0;
        v1 = 1;
        s1 = 16'd66;
        v2 = 1;
        s2 = 16'd55;
        step();
        v1 = 0;
        v2 = 0;
        check("post_u1", 32'(o1), 32'd66);
        check("post_u2", 32'(o2), 32'd55);
        check("post_lvl2", 32'(l2), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
